// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, mode-0 line conventions and the responder FSM states.
package spi_pkg;

    localparam int   SPI_DATA_W    = 8;
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;
    localparam logic SPI_CS_IDLE   = 1'b1;
    localparam logic SPI_DATA_IDLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        SHIFT
    } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous bit with rise/fall pulses taken after the last stage.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LVL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversampled sck/cs_n/mosi, MSB-first shift in/out, per-word strobes.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] DIN,
    output logic              tx_ack,
    output logic [DATA_W-1:0] DOUT,
    output logic              rx_valid,
    output logic              bsy
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic sck_lvl, cs_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(SPI_CPOL)) u_sck_sync (
        .clk(clk), .rst(rst), .async_i(sck),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(SPI_CS_IDLE)) u_cs_sync (
        .clk(clk), .rst(rst), .async_i(cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(SPI_DATA_IDLE)) u_mosi_sync (
        .clk(clk), .rst(rst), .async_i(mosi),
        .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_edges = &{1'b0, sck_lvl, cs_lvl, mosi_rise, mosi_fall};

    spi_state_e        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] tx_shift_q, rx_shift_q, rx_shift_d, dout_q;
    logic              miso_q, miso_oe_q, tx_ack_q, rx_valid_q, bsy_q;

    assign rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};

    // cs_n rising wins over any sck edge detected in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            dout_q     <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            bsy_q      <= 1'b0;
        end else begin
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    bsy_q     <= 1'b0;
                    bit_cnt_q <= '0;
                    if (cs_fall) state_q <= SELECT;
                end
                SELECT: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end else begin
                        tx_shift_q <= DIN;
                        tx_ack_q   <= 1'b1;
                        bit_cnt_q  <= '0;
                        bsy_q      <= 1'b1;
                        miso_oe_q  <= 1'b1;
                        miso_q     <= DIN[DATA_W-1];
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        bsy_q     <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (sck_rise) begin
                        rx_shift_q <= rx_shift_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q  <= '0;
                            dout_q     <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        // Falling edge at a word boundary loads the next transmit word.
                        if (bit_cnt_q == '0) begin
                            tx_shift_q <= DIN;
                            tx_ack_q   <= 1'b1;
                            miso_q     <= DIN[DATA_W-1];
                        end else begin
                            tx_shift_q <= tx_shift_q << 1;
                            miso_q     <= tx_shift_q[DATA_W-2];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ack   = tx_ack_q;
    assign DOUT     = dout_q;
    assign rx_valid = rx_valid_q;
    assign bsy      = bsy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave; the bench itself plays the SPI master.
module tb_spi_slave;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst, sck, cs_n, mosi;
    logic              miso, miso_oe, tx_ack, rx_valid, bsy;
    logic [DATA_W-1:0] DIN, DOUT;

    int checks   = 0;
    int failures = 0;
    int rxv_cnt  = 0;
    int ack_cnt  = 0;

    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] mtx_q[$];
    logic [DATA_W-1:0] din_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_miso_q[$];
    logic              frame_done;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .DIN(DIN), .tx_ack(tx_ack),
        .DOUT(DOUT), .rx_valid(rx_valid), .bsy(bsy)
    );

    // Monitor: pulse counters and received-word log.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rxv_cnt = rxv_cnt + 1;
                got_q.push_back(DOUT);
            end
            if (tx_ack) ack_cnt = ack_cnt + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bits(input logic [DATA_W-1:0] tx, input int nbits, input int hp,
                             output logic [DATA_W-1:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[DATA_W-1-i];
            repeat (hp) @(negedge clk);
            rx = {rx[DATA_W-2:0], miso};
            sck = 1'b1;
            repeat (hp) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic wait_oe_drop(input string tag);
        for (int c = 0; c <= SYNC_STAGES + 2; c++) begin
            @(negedge clk);
            if (!miso_oe) break;
        end
        chk(tag, 32'(miso_oe), 32'(0));
    endtask

    // One full select: sends mtx_q, feeds din_q into DIN on each tx_ack, checks everything.
    task automatic run_frame(input int hp, input string tag);
        int                n, rxv0, ack0, idx;
        logic [DATA_W-1:0] last, r;
        logic [31:0]       obs;
        n    = mtx_q.size();
        rxv0 = rxv_cnt;
        ack0 = ack_cnt;
        exp_q = mtx_q;
        exp_miso_q.delete();
        last = DIN;
        exp_miso_q.push_back(last);
        for (int k = 1; k < n; k++) begin
            if (k - 1 < din_q.size()) last = din_q[k-1];
            exp_miso_q.push_back(last);
        end
        cs_n = 1'b0;
        frame_done = 1'b0;
        fork
            begin
                repeat (hp + 2) @(negedge clk);
                for (int k = 0; k < n; k++) begin
                    xfer_bits(mtx_q[k], DATA_W, hp, r);
                    chk($sformatf("%s miso_word%0d", tag, k), 32'(r), 32'(exp_miso_q[k]));
                end
                repeat (hp) @(negedge clk);
                frame_done = 1'b1;
            end
            begin
                while (!frame_done) begin
                    @(negedge clk);
                    if (tx_ack && din_q.size() > 0) DIN = din_q.pop_front();
                end
            end
        join
        chk({tag, " bsy"}, 32'(bsy), 32'(1));
        chk({tag, " miso_oe"}, 32'(miso_oe), 32'(1));
        cs_n = 1'b1;
        wait_oe_drop({tag, " oe_drop"});
        repeat (4) @(negedge clk);
        chk({tag, " bsy_idle"}, 32'(bsy), 32'(0));
        chk({tag, " rx_valid_cnt"}, 32'(rxv_cnt - rxv0), 32'(n));
        chk({tag, " tx_ack_cnt"}, 32'(ack_cnt - ack0), 32'(n + 1));
        for (int k = 0; k < n; k++) begin
            idx = rxv0 + k;
            obs = (idx < got_q.size()) ? 32'(got_q[idx]) : 'x;
            chk($sformatf("%s dout_word%0d", tag, k), obs, 32'(exp_q[k]));
        end
        chk({tag, " dout_hold"}, 32'(DOUT), 32'(exp_q[n-1]));
        mtx_q.delete();
        din_q.delete();
    endtask

    initial begin
        int                rxv0, ack0, hp, nw;
        logic [DATA_W-1:0] r;

        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; DIN = '0;

        // Reset while sck toggles with cs_n high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sck = ~sck;
        end
        sck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("reset miso", 32'(miso), 32'(0));
        chk("reset miso_oe", 32'(miso_oe), 32'(0));
        chk("reset tx_ack", 32'(tx_ack), 32'(0));
        chk("reset rx_valid", 32'(rx_valid), 32'(0));
        chk("reset dout", 32'(DOUT), 32'(0));
        chk("reset bsy", 32'(bsy), 32'(0));
        for (int i = 0; i < 6; i++) begin
            repeat (4) @(negedge clk);
            sck = ~sck;
        end
        repeat (6) @(negedge clk);
        chk("idle no tx_ack", 32'(ack_cnt), 32'(0));
        chk("idle no rx_valid", 32'(rxv_cnt), 32'(0));

        // Single word.
        DIN = 8'h3C;
        mtx_q.push_back(8'hA5);
        run_frame(4, "single");

        // Back-to-back words in one select.
        DIN = 8'h3C;
        mtx_q.push_back(8'h01); mtx_q.push_back(8'hFF); mtx_q.push_back(8'h80);
        din_q.push_back(8'h55); din_q.push_back(8'hAA);
        run_frame(4, "b2b");

        // Abort after 5 bits: partial word discarded.
        DIN  = 8'h66;
        rxv0 = rxv_cnt;
        ack0 = ack_cnt;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        xfer_bits(8'hF0, 5, 4, r);
        chk("abort miso_bits", 32'(r), 32'(8'h0C));
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        wait_oe_drop("abort oe_drop");
        repeat (4) @(negedge clk);
        chk("abort no rx_valid", 32'(rxv_cnt - rxv0), 32'(0));
        chk("abort tx_ack_cnt", 32'(ack_cnt - ack0), 32'(1));
        chk("abort dout_kept", 32'(DOUT), 32'(8'h80));
        DIN = 8'($urandom);
        mtx_q.push_back(8'($urandom));
        run_frame(4, "after_abort");

        // Reset in the middle of bit 3.
        DIN  = 8'($urandom);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        xfer_bits(8'($urandom), 3, 5, r);
        mosi = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
        chk("midrst miso", 32'(miso), 32'(0));
        chk("midrst miso_oe", 32'(miso_oe), 32'(0));
        chk("midrst bsy", 32'(bsy), 32'(0));
        chk("midrst dout", 32'(DOUT), 32'(0));
        chk("midrst rx_valid", 32'(rx_valid), 32'(0));
        @(negedge clk);
        rst  = 1'b0;
        rxv0 = rxv_cnt;
        ack0 = ack_cnt;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            repeat (4) @(negedge clk);
            sck = ~sck;
        end
        repeat (6) @(negedge clk);
        chk("midrst sck_ignored rx", 32'(rxv_cnt - rxv0), 32'(0));
        chk("midrst sck_ignored ack", 32'(ack_cnt - ack0), 32'(0));
        chk("midrst still idle", 32'(miso_oe), 32'(0));
        DIN = 8'($urandom);
        mtx_q.push_back(8'($urandom));
        run_frame(4, "after_rst");

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            hp  = int'($urandom_range(4, 8));
            nw  = int'($urandom_range(1, 3));
            DIN = 8'($urandom);
            for (int k = 0; k < nw; k++) begin
                mtx_q.push_back(8'($urandom));
                din_q.push_back(8'($urandom));
            end
            run_frame(hp, $sformatf("rand%0d", f));
        end

        // Loopback-style exchange with a slow sck.
        DIN = 8'hC3;
        mtx_q.push_back(8'h5A);
        run_frame(10, "loopback");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
